// File: rtl/alu_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_sequencer
// Purpose  : Parallel-side driver/collector for the 1-bit serial ALU. Latches
//            two operands, an opcode and a shift amount. Streams operand bits
//            LSB-first with alu_start/alu_en framing. Deserializes the
//            registered alu_result stream into a word and pulses done.
// Ports    : clk, rst_n (sync, active-low)
//            start, op, op_a, op_b, shamt  - operation request (IDLE only)
//            busy, done, result            - status / parallel result
//            alu_rs1, alu_rs2, alu_op,
//            alu_en, alu_start             - serial ALU drive
//            alu_result                    - registered serial ALU output
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial_sequencer #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               alu_rs1,
  output logic               alu_rs2,
  output logic [2:0]         alu_op,
  output logic               alu_en,
  output logic               alu_start,
  input  logic               alu_result
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_PRE   = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  localparam logic [2:0] c_OP_SLLI = 3'b101;
  localparam logic [2:0] c_OP_SRLI = 3'b110;

  localparam logic [SHAMT_W-1:0] c_LAST_BIT = SHAMT_W'(WIDTH - 1);

  logic [1:0]         state_q,  state_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic [SHAMT_W-1:0] sh_q,     sh_d;
  logic [WIDTH-1:0]   sr_q,     sr_d;
  logic               en_dly_q, en_dly_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               rs1_q,    rs1_d;
  logic               rs2_q,    rs2_d;
  logic [2:0]         aluop_q,  aluop_d;
  logic               en_q,     en_d;
  logic               astart_q, astart_d;

  // Index of the bit presented during the next cycle. Outputs are registered,
  // so the bit for cycle i is selected on the edge that enters it.
  logic [SHAMT_W-1:0] w_idx;
  logic [WIDTH-1:0]   w_rs1_vec;

  assign w_idx = (state_q == c_PRE) ? '0 : cnt_q + SHAMT_W'(1);

  // Pre-shifted rs1 word; zero-fill gives the out-of-range-is-0 behaviour.
  always_comb begin
    w_rs1_vec = a_q;
    if (aluop_q == c_OP_SLLI)      w_rs1_vec = a_q << sh_q;
    else if (aluop_q == c_OP_SRLI) w_rs1_vec = a_q >> sh_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rs1_d    = 1'b0;
    rs2_d    = 1'b0;
    aluop_d  = aluop_q;
    en_d     = 1'b0;
    astart_d = 1'b0;
    // ALU result lags alu_en by one registered stage, so capture is keyed on
    // the delayed enable.
    en_dly_d = en_q;
    sr_d     = en_dly_q ? {alu_result, sr_q[WIDTH-1:1]} : sr_q;

    case (state_q)
      c_IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          sh_d     = shamt;
          aluop_d  = op;
          astart_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = c_PRE;
        end
      end
      c_PRE: begin
        cnt_d   = '0;
        en_d    = 1'b1;
        rs1_d   = w_rs1_vec[w_idx];
        rs2_d   = b_q[w_idx];
        state_d = c_RUN;
      end
      c_RUN: begin
        if (cnt_q == c_LAST_BIT) begin
          state_d = c_DRAIN;
        end else begin
          cnt_d = w_idx;
          en_d  = 1'b1;
          rs1_d = w_rs1_vec[w_idx];
          rs2_d = b_q[w_idx];
        end
      end
      default: begin
        // DRAIN: the final captured bit lands in sr_d on this same edge.
        cnt_d    = '0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = sr_d;
        state_d  = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= c_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      sr_q     <= '0;
      en_dly_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rs1_q    <= 1'b0;
      rs2_q    <= 1'b0;
      aluop_q  <= 3'b000;
      en_q     <= 1'b0;
      astart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      sr_q     <= sr_d;
      en_dly_q <= en_dly_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      aluop_q  <= aluop_d;
      en_q     <= en_d;
      astart_q <= astart_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign alu_rs1   = rs1_q;
  assign alu_rs2   = rs2_q;
  assign alu_op    = aluop_q;
  assign alu_en    = en_q;
  assign alu_start = astart_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_sequencer
// Purpose  : Self-checking bench for alu_serial_sequencer with a behavioural
//            serial ALU and a word-level arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial_sequencer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0] shamt = 3'd0;
  logic       busy, done;
  logic [W-1:0] result;
  logic       alu_rs1, alu_rs2, alu_en, alu_start;
  logic [2:0] alu_op;
  logic       alu_result = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] cur_exp;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(W), .SHAMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a),
    .op_b(op_b), .shamt(shamt), .busy(busy), .done(done), .result(result),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_en(alu_en),
    .alu_start(alu_start), .alu_result(alu_result)
  );

  // Behavioural 1-bit serial ALU with a registered result bit.
  logic alu_c = 1'b0;
  always @(posedge clk) begin
    if (alu_start) begin
      alu_c <= (alu_op == 3'b001);
    end else if (alu_en) begin
      case (alu_op)
        3'b000: begin
          alu_result <= alu_rs1 ^ alu_rs2 ^ alu_c;
          alu_c      <= (alu_rs1 & alu_rs2) | (alu_c & (alu_rs1 ^ alu_rs2));
        end
        3'b001: begin
          alu_result <= alu_rs1 ^ ~alu_rs2 ^ alu_c;
          alu_c      <= (alu_rs1 & ~alu_rs2) | (alu_c & (alu_rs1 ^ ~alu_rs2));
        end
        3'b010:  alu_result <= alu_rs1 ^ alu_rs2;
        3'b011:  alu_result <= alu_rs1 & alu_rs2;
        3'b100:  alu_result <= alu_rs1 | alu_rs2;
        3'b101,
        3'b110:  alu_result <= alu_rs1;
        default: alu_result <= 1'b0;
      endcase
    end
  end

  function automatic logic [W-1:0] ref_model(input logic [2:0] o,
      input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sh);
    case (o)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a ^ b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a << sh;
      3'b110:  return a >> sh;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge samples start (cycle T).
  task automatic launch(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] sh);
    start = 1'b1; op = o; op_a = a; op_b = b; shamt = sh;
    cur_exp = ref_model(o, a, b, sh);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); op_a = W'($urandom); op_b = W'($urandom);
    shamt = 3'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("alu_start_pre", {31'd0, alu_start}, 32'd1);
    check("alu_op_pre", {29'd0, alu_op}, {29'd0, o});
    check("done_low_pre", {31'd0, done}, 32'd0);
  endtask

  // Waits (bounded) for done; optionally pulses start at cycle T+4.
  // Returns at the negedge on which done is high.
  task automatic finish_op(input string tag, input bit poke);
    int cyc = 0;
    while (!done && cyc < 30) begin
      if (poke && cyc == 3) begin
        start = 1'b1; op = 3'b001; op_a = 8'hFF; op_b = 8'h77;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, W + 2);
    check({tag, "_result"}, {24'd0, result}, {24'd0, cur_exp});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
      input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sh);
    launch(o, a, b, sh);
    finish_op(tag, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_alu_ctl", {26'd0, alu_en, alu_start, alu_rs1, alu_rs2, 2'd0},
          32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add", 3'b000, 8'h5A, 8'h3C, 3'd0);
    run_op("sub1", 3'b001, 8'h10, 8'h01, 3'd0);
    run_op("sub2", 3'b001, 8'h00, 8'h01, 3'd0);
    // Back-to-back: launched in the done cycle of the previous op.
    run_op("b2b_add0", 3'b000, 8'h00, 8'h00, 3'd0);
    run_op("slli3", 3'b101, 8'h81, 8'h00, 3'd3);
    run_op("srli3", 3'b110, 8'h81, 8'h00, 3'd3);
    run_op("slli0", 3'b101, 8'h81, 8'h55, 3'd0);
    run_op("xor", 3'b010, 8'hF0, 8'h3C, 3'd0);
    run_op("and", 3'b011, 8'hF0, 8'h3C, 3'd0);
    run_op("or", 3'b100, 8'hF0, 8'h3C, 3'd0);
    run_op("nop", 3'b111, 8'hF0, 8'h3C, 3'd0);

    // start during busy is ignored.
    @(negedge clk);
    launch(3'b000, 8'h5A, 8'h3C, 3'd0);
    finish_op("ignored_start", 1'b1);
    @(negedge clk);
    check("single_done", {31'd0, done}, 32'd0);
    check("idle_after_poke", {31'd0, busy}, 32'd0);

    // Randomized ops, some back-to-back, some with idle gaps.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) @(negedge clk);
      run_op("rand", 3'($urandom), W'($urandom), W'($urandom),
             3'($urandom));
    end

    // Reset mid-operation at RUN bit 4.
    @(negedge clk);
    launch(3'b000, 8'h33, 8'h44, 3'd0);
    repeat (5) @(negedge clk);
    check("mid_run_en", {31'd0, alu_en}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_alu_en", {31'd0, alu_en}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("abort_no_done", seen, 0);
    end
    run_op("post_rst_add", 3'b000, 8'h01, 8'h01, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Parallel-side driver and collector for the team's 1-bit serial ALU. Latches two WIDTH-bit operands, an opcode and a shift amount. Streams operand bits LSB-first into the ALU with correct alu_start/alu_en framing, deserializes the registered alu_result stream back into a parallel word, and reports completion with a done pulse. Sits between the decode/regfile stage and the serial ALU.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2
SHAMT_W, 3, width of the shamt input; WIDTH must equal 2**SHAMT_W

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
op  input  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 SLLI, 110 SRLI, 111 none (result 0)
op_a  input  WIDTH  operand rs1
op_b  input  WIDTH  operand rs2
shamt  input  SHAMT_W  shift amount for SLLI/SRLI; ignored for other ops
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  last completed result; held until the next done
alu_rs1  output  1  serial rs1 bit to the ALU
alu_rs2  output  1  serial rs2 bit to the ALU
alu_op  output  3  opcode to the ALU
alu_en  output  1  ALU bit-enable
alu_start  output  1  ALU carry-preload strobe
alu_result  input  1  registered serial result from the ALU

Behaviour:
- Reset is synchronous, active-low, on clk via rst_n. Reset values: state=IDLE; busy, done, alu_rs1, alu_rs2, alu_en, alu_start = 0; alu_op = 000; result = 0; bit counter = 0.
- All outputs are registered.
- FSM states: IDLE -> PRE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - On start=1: latch op, op_a, op_b, shamt; go to PRE; busy=1 from the next cycle.
  - start while busy=1 is ignored; latched operands stay unchanged.
- PRE (1 cycle):
  - alu_start=1, alu_en=0, alu_op=latched op.
  - This flushes the ALU carry to 1 for SUB and to 0 for all other ops. It guarantees no carry leaks from a previous operation.
- RUN (WIDTH cycles, bit index i = 0..WIDTH-1):
  - alu_en=1, alu_start=0, alu_rs2 = op_b[i].
  - alu_rs1 by op:
    - SLLI: op_a[i-shamt] if i >= shamt, else 0.
    - SRLI: op_a[i+shamt] if i+shamt < WIDTH, else 0.
    - All other ops: op_a[i].
- DRAIN (1 cycle): alu_en=0, alu_rs1=alu_rs2=0. This cycle captures the final bit.
- Capture:
  - The ALU result lags alu_en by one cycle.
  - On every cycle where the previous cycle had alu_en=1, shift alu_result into the MSB of an internal shift register, shifting right.
  - After WIDTH captures, the register holds the LSB-first-assembled word.
- Completion:
  - On the DRAIN->IDLE edge, copy the shift register to result and set done=1 for exactly one cycle. busy=0 in that same cycle.
- Latency: start sampled at cycle T -> done high at T+WIDTH+3 (T+11 for WIDTH=8).
- Back-to-back: start asserted during the done cycle is accepted (the FSM is in IDLE). Throughput is one op per WIDTH+3 cycles.
- alu_op holds its value through PRE, RUN and DRAIN, and keeps its last value in IDLE.
- Arithmetic: modulo 2**WIDTH; carry/borrow out is discarded. shamt=0 passes op_a unchanged.
- Reset mid-operation: abort immediately and return to the reset values. No done pulse. result clears to 0. The next operation after reset behaves normally.
- op=111: runs the full sequence; result=0; done still pulses.

Test Plan:
- ADD op_a=0x5A, op_b=0x3C, start at T -> busy from T+1, done at T+11, result=0x96.
- SUB 0x10-0x01 -> result=0x0F. SUB 0x00-0x01 -> result=0xFF. Then back-to-back ADD 0x00+0x00 started in the done cycle -> result=0x00, confirming no carry leak.
- SLLI op_a=0x81, shamt=3 -> result=0x08. SRLI op_a=0x81, shamt=3 -> result=0x10. SLLI with shamt=0 -> result=0x81.
- Logic ops with a=0xF0, b=0x3C: XOR -> 0xCC, AND -> 0x30, OR -> 0xFC. op=111 -> result 0x00 with done pulse.
- Pulse start again at T+4 during an ADD -> ignored; a single done at T+11 with the original result.
- Assert rst_n=0 at RUN bit 4 -> next cycle busy=0, result=0, alu_en=0, no done. After release, ADD 0x01+0x01 -> result=0x02.
